// File: rtl/mont_final_sub.sv
// Final Montgomery reduction: subtracts the modulus from the adder sum once per cycle until the
// value drops below M. The value is bounded to MAX_SUB subtractions, and the result is returned
// over a valid/ready handshake.
module mont_final_sub #(
    parameter int WIDTH    = 1024,
    parameter int IN_WIDTH = 1028,
    parameter int MAX_SUB  = 3,
    parameter int CW       = $clog2(MAX_SUB + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0]    modulus,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic [CW-1:0]       out_nsub,
    output logic                out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [IN_WIDTH-1:0] x_r;
    logic [IN_WIDTH-1:0] x_nx_s;
    logic [IN_WIDTH:0]   d_r;
    logic [IN_WIDTH:0]   d_nx_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nx_s;
    logic [IN_WIDTH-1:0] minuend_s;
    logic [IN_WIDTH:0]   diff_s;
    logic                load_out_s;
    logic                err_nx_s;
    logic [WIDTH-1:0]    out_result_r;
    logic [CW-1:0]       out_nsub_r;
    logic                out_err_r;

    // d_r always holds X - M (borrow in the MSB), so each SUB cycle decides from a registered
    // difference while the single subtractor prepares the next one.
    // Shared subtractor: primes from X in PREP, chains from the held difference in SUB.
    always_comb begin
        if (state_r == SUB) begin
            minuend_s = d_r[IN_WIDTH-1:0];
        end else begin
            minuend_s = x_r;
        end
        diff_s = {1'b0, minuend_s} - {{(IN_WIDTH + 1 - WIDTH){1'b0}}, modulus};
    end

    // Next-state and datapath update decisions.
    always_comb begin
        state_nx_s = state_r;
        x_nx_s     = x_r;
        d_nx_s     = d_r;
        cnt_nx_s   = cnt_r;
        load_out_s = 1'b0;
        err_nx_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    x_nx_s     = in_sum;
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = PREP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PREP: begin
                d_nx_s     = diff_s;
                state_nx_s = SUB;
            end
            SUB: begin
                if (d_r[IN_WIDTH]) begin
                    state_nx_s = DONE;
                    load_out_s = 1'b1;
                    err_nx_s   = 1'b0;
                end else if (cnt_r == CW'(MAX_SUB)) begin
                    state_nx_s = DONE;
                    load_out_s = 1'b1;
                    err_nx_s   = 1'b1;
                end else begin
                    x_nx_s   = d_r[IN_WIDTH-1:0];
                    cnt_nx_s = cnt_r + CW'(1);
                    d_nx_s   = diff_s;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and working registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
            x_r     <= {IN_WIDTH{1'b0}};
            d_r     <= {(IN_WIDTH + 1){1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            x_r     <= x_nx_s;
            d_r     <= d_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Result registers load only when a transaction completes, so they hold through IDLE and SUB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_result_r <= {WIDTH{1'b0}};
            out_nsub_r   <= {CW{1'b0}};
            out_err_r    <= 1'b0;
        end else if (load_out_s) begin
            out_result_r <= x_r[WIDTH-1:0];
            out_nsub_r   <= cnt_r;
            out_err_r    <= err_nx_s;
        end else begin
            out_result_r <= out_result_r;
            out_nsub_r   <= out_nsub_r;
            out_err_r    <= out_err_r;
        end
    end

    assign in_ready   = (state_r == IDLE) && resetn;
    assign out_valid  = (state_r == DONE);
    assign out_result = out_result_r;
    assign out_nsub   = out_nsub_r;
    assign out_err    = out_err_r;

endmodule
